channel_event_arbiter: RTL



---
 rtl/channel_event_arbiter_if.sv | 26 ++
 rtl/channel_event_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/channel_event_arbiter_if.sv
// Event arbiter bus: capture controls in, serialised channel codes out.
// The master side drives the channel levels and the downstream ready.
// The slave side is the arbiter itself.
interface channel_event_arbiter_if #(
  parameter int N_CH   = 7,
  parameter int CODE_W = 3
);
  logic              en;
  logic [N_CH-1:0]   ch_in;
  logic              evt_ready;
  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic [N_CH-1:0]   ovf;
  logic              ovf_clr;
  logic              busy;

  modport master (
    output en, ch_in, evt_ready, ovf_clr,
    input  evt_valid, evt_code, ovf, busy
  );

  modport slave (
    input  en, ch_in, evt_ready, ovf_clr,
    output evt_valid, evt_code, ovf, busy
  );
endinterface

// File: rtl/channel_event_arbiter.sv
// Channel event arbiter: turns rising edges on the channel detector levels
// into per-channel pending flags, then serialises them round-robin onto a
// registered valid/ready stream as channel codes (index + 1, 0 = none).
module channel_event_arbiter #(
  parameter int N_CH   = 7,
  parameter int CODE_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  channel_event_arbiter_if.slave  bus
);

  // The pointer only ever holds a channel index, which fits in CODE_W bits
  // because the code space must also hold index+1.
  localparam int PTR_W = CODE_W;

  logic [N_CH-1:0]   ch_prev_reg;
  logic [N_CH-1:0]   pending_reg,  pending_next;
  logic [N_CH-1:0]   ovf_reg,      ovf_next;
  logic [PTR_W-1:0]  rr_ptr_reg,   rr_ptr_next;
  logic              evt_valid_reg, evt_valid_next;
  logic [CODE_W-1:0] evt_code_reg,  evt_code_next;

  logic [N_CH-1:0]   edge_det;
  logic [N_CH-1:0]   ovf_set;
  logic [N_CH-1:0]   grant_mask;
  logic              slot_free;
  logic              grant_found;
  logic [PTR_W-1:0]  grant_idx;

  // The output register can take a new event when empty or being accepted.
  assign slot_free = ~evt_valid_reg | bus.evt_ready;

  // Per-channel edge detection and overflow detection. An edge on a channel
  // that is still pending and not being granted this cycle is merged and
  // flagged; an edge coinciding with its own grant simply re-arms pending.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign edge_det[gi] = bus.en & bus.ch_in[gi] & ~ch_prev_reg[gi];
      assign ovf_set[gi]  = edge_det[gi] & pending_reg[gi] & ~grant_mask[gi];
    end
  endgenerate

  // Round-robin search: first pending channel at or above rr_ptr, wrapping.
  always_comb begin
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int off = 0; off < N_CH; off++) begin
      cand = int'(rr_ptr_reg) + off;
      if (cand >= N_CH) begin
        cand = cand - N_CH;
      end
      cand_idx = PTR_W'(cand);
      if (!grant_found && pending_reg[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Output stage, pointer advance and pending/overflow bookkeeping.
  always_comb begin
    grant_mask     = '0;
    evt_valid_next = evt_valid_reg;
    evt_code_next  = evt_code_reg;
    rr_ptr_next    = rr_ptr_reg;
    if (slot_free) begin
      if (grant_found) begin
        grant_mask[grant_idx] = 1'b1;
        evt_valid_next        = 1'b1;
        evt_code_next         = CODE_W'(grant_idx) + CODE_W'(1);
        if (int'(grant_idx) == N_CH - 1) begin
          rr_ptr_next = '0;
        end else begin
          rr_ptr_next = grant_idx + PTR_W'(1);
        end
      end else begin
        evt_valid_next = 1'b0;
        evt_code_next  = '0;
      end
    end
    // A new edge wins over the clear from its own grant.
    pending_next = (pending_reg & ~grant_mask) | edge_det;
    // A fresh overflow wins over the clear request.
    ovf_next     = (bus.ovf_clr ? '0 : ovf_reg) | ovf_set;
  end

  // State registers; reset drops any in-flight event immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_prev_reg   <= '0;
      pending_reg   <= '0;
      ovf_reg       <= '0;
      rr_ptr_reg    <= '0;
      evt_valid_reg <= 1'b0;
      evt_code_reg  <= '0;
    end else begin
      ch_prev_reg   <= bus.ch_in;
      pending_reg   <= pending_next;
      ovf_reg       <= ovf_next;
      rr_ptr_reg    <= rr_ptr_next;
      evt_valid_reg <= evt_valid_next;
      evt_code_reg  <= evt_code_next;
    end
  end

  assign bus.evt_valid = evt_valid_reg;
  assign bus.evt_code  = evt_code_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.busy      = (|pending_reg) | evt_valid_reg;

endmodule
